// File: rtl/spi_byte_master.sv
// Byte-wide SPI master: shifts one byte out on mosi while sampling the selected MISO line.
// All outputs are registered; fsm_state exposes the controller state for observation.
module spi_byte_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int NUM_MISO          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          spitx,
  input  logic                spitxdv,
  output logic                spitxready,
  output logic [7:0]          spirx,
  output logic                spirxdv,
  input  logic [2:0]          spimisossel,
  input  logic [NUM_MISO-1:0] spimiso,
  output logic                sclk,
  output logic                mosi,
  output logic [1:0]          fsm_state
);

  localparam logic CPOL = 1'(SPI_MODE >> 1);
  localparam logic CPHA = 1'(SPI_MODE);
  localparam int   HW   = (CLKS_PER_HALF_BIT > 2) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

  // Handshake: a byte is taken on a rising clk edge where spitxdv=1 and spitxready=1;
  // spirxdv is a one-cycle pulse and spirx holds its value until the next completion.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_cnt;
  logic [4:0]    edge_cnt;
  logic [7:0]    tx_sr, rx_sr;
  logic [2:0]    sel_q;
  logic [7:0]    miso_pad;
  logic          miso_bit, accept, shifting, half_wrap, leading, sample_now, drive_now;

  assign fsm_state = state_q;

  always_comb begin
    // Unpopulated select positions read as constant 0.
    miso_pad                 = '0;
    miso_pad[NUM_MISO-1:0]   = spimiso;
    miso_bit                 = miso_pad[sel_q];
    accept                   = spitxdv && spitxready;
    shifting                 = (state_q == S_SHIFT) && (edge_cnt != 5'd16);
    half_wrap                = shifting && (half_cnt == HALF_LAST);
    leading                  = ~edge_cnt[0];
    sample_now               = half_wrap && (leading ^ CPHA);
    drive_now                = half_wrap && (CPHA ? leading : (!leading && edge_cnt < 5'd14));
    state_d                  = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (edge_cnt == 5'd16) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      half_cnt   <= '0;
      edge_cnt   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      sel_q      <= '0;
      sclk       <= CPOL;
      mosi       <= 1'b0;
      spitxready <= 1'b0;
      spirxdv    <= 1'b0;
      spirx      <= '0;
    end else begin
      state_q    <= state_d;
      spitxready <= (state_d != S_SHIFT);
      spirxdv    <= (state_d == S_DONE);
      if (state_d == S_DONE) spirx <= rx_sr;
      if (accept) begin
        tx_sr    <= spitx;
        sel_q    <= spimisossel;
        rx_sr    <= '0;
        half_cnt <= '0;
        edge_cnt <= '0;
        if (!CPHA) mosi <= spitx[7];
      end else if (shifting) begin
        if (half_wrap) begin
          half_cnt <= '0;
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + 5'd1;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
        if (sample_now) rx_sr <= {rx_sr[6:0], miso_bit};
        // Mode 0/2 pre-loads bit 7 at acceptance, so trailing edges drive from bit 6.
        if (drive_now) begin
          mosi  <= CPHA ? tx_sr[7] : tx_sr[6];
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: three instances (mode 0 H=2, mode 3 H=3, mode 0 H=2 with 4 MISO lines)
// driven by byte transactions, with an SPI slave model and a scoreboard of expected completions.
module tb_spi_byte_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] tx_v [3];
  logic       txdv_v [3];
  logic [2:0] sel_v [3];
  logic       rdy_v [3];
  logic [7:0] rx_v [3];
  logic       dv_v [3];
  logic       sclk_v [3];
  logic       mosi_v [3];
  logic [1:0] st_v [3];

  logic [7:0] miso0, miso1, miso2_full;
  logic [3:0] miso2;

  // slave model state
  logic [2:0] slv_sel [3];
  logic       slv_loop [3];
  logic       slv_bit [3];
  logic [7:0] slv_byte [3];
  logic [7:0] noise [3];
  logic       noise_rand [3];
  int         rise_cnt [3];
  int         fall_cnt [3];
  logic [7:0] mosi_cap [3];
  logic       prev_sclk [3];

  // scoreboard entries: {dv_cycle[15:0], expected mosi byte, expected rx byte}
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mk_miso(input logic [7:0] nz, input logic [2:0] s, input logic b);
    logic [7:0] m;
    m    = nz;
    m[s] = b;
    return m;
  endfunction

  assign miso0      = mk_miso(noise[0], slv_sel[0], slv_loop[0] ? mosi_v[0] : slv_bit[0]);
  assign miso1      = mk_miso(noise[1], slv_sel[1], slv_loop[1] ? mosi_v[1] : slv_bit[1]);
  assign miso2_full = mk_miso(noise[2], slv_sel[2], slv_loop[2] ? mosi_v[2] : slv_bit[2]);
  assign miso2      = miso2_full[3:0];

  spi_byte_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2), .NUM_MISO(8)) dut0 (
    .clk(clk), .rst(rst), .spitx(tx_v[0]), .spitxdv(txdv_v[0]), .spitxready(rdy_v[0]),
    .spirx(rx_v[0]), .spirxdv(dv_v[0]), .spimisossel(sel_v[0]), .spimiso(miso0),
    .sclk(sclk_v[0]), .mosi(mosi_v[0]), .fsm_state(st_v[0]));

  spi_byte_master #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(3), .NUM_MISO(8)) dut1 (
    .clk(clk), .rst(rst), .spitx(tx_v[1]), .spitxdv(txdv_v[1]), .spitxready(rdy_v[1]),
    .spirx(rx_v[1]), .spirxdv(dv_v[1]), .spimisossel(sel_v[1]), .spimiso(miso1),
    .sclk(sclk_v[1]), .mosi(mosi_v[1]), .fsm_state(st_v[1]));

  spi_byte_master #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2), .NUM_MISO(4)) dut2 (
    .clk(clk), .rst(rst), .spitx(tx_v[2]), .spitxdv(txdv_v[2]), .spitxready(rdy_v[2]),
    .spirx(rx_v[2]), .spirxdv(dv_v[2]), .spimisossel(sel_v[2]), .spimiso(miso2),
    .sclk(sclk_v[2]), .mosi(mosi_v[2]), .fsm_state(st_v[2]));

  function automatic int hh(input int d);
    return (d == 1) ? 3 : 2;
  endfunction

  function automatic int numm(input int d);
    return (d == 2) ? 4 : 8;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic void qpush(input int d, input logic [31:0] e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endfunction

  function automatic logic [31:0] qpop(input int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  // Monitor: slave model on sclk edges plus scoreboard compare on every spirxdv.
  always @(negedge clk) begin
    logic [31:0] e;
    int k;
    for (int d = 0; d < 3; d++) begin
      if (noise_rand[d]) noise[d] = 8'($urandom);
      if (rst) begin
        rise_cnt[d]  = 0;
        fall_cnt[d]  = 0;
        mosi_cap[d]  = '0;
        prev_sclk[d] = sclk_v[d];
      end else begin
        if (!prev_sclk[d] && sclk_v[d]) begin
          rise_cnt[d]++;
          mosi_cap[d] = {mosi_cap[d][6:0], mosi_v[d]};
        end
        if (prev_sclk[d] && !sclk_v[d]) begin
          fall_cnt[d]++;
          k = fall_cnt[d];
          if (d == 1 && k <= 8) slv_bit[d] = slv_byte[d][8-k];
          else if (d != 1 && k <= 7) slv_bit[d] = slv_byte[d][7-k];
        end
        prev_sclk[d] = sclk_v[d];
        if (dv_v[d]) begin
          if (qsize(d) == 0) begin
            chk($sformatf("unexpected_rxdv_d%0d", d), 32'd1, 32'd0);
          end else begin
            e = qpop(d);
            chk($sformatf("spirx_d%0d", d), {24'd0, rx_v[d]}, {24'd0, e[7:0]});
            chk($sformatf("mosi_byte_d%0d", d), {24'd0, mosi_cap[d]}, {24'd0, e[15:8]});
            chk($sformatf("rise_count_d%0d", d), 32'(rise_cnt[d]), 32'd8);
            chk($sformatf("rxdv_cycle_d%0d", d), {16'd0, 16'(cyc)}, {16'd0, e[31:16]});
            chk($sformatf("ready_in_done_d%0d", d), {31'd0, rdy_v[d]}, 32'd1);
          end
          rise_cnt[d] = 0;
          fall_cnt[d] = 0;
          mosi_cap[d] = '0;
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] tx, input logic [2:0] sel,
                      input logic [7:0] sb, input logic lp, output int acc);
    int t;
    logic [7:0] erx;
    t   = 0;
    acc = 0;
    forever begin
      @(negedge clk);
      if (rdy_v[d]) break;
      t++;
      if (t > 300) begin
        chk($sformatf("ready_timeout_d%0d", d), 32'd0, 32'd1);
        return;
      end
    end
    tx_v[d]     = tx;
    sel_v[d]    = sel;
    txdv_v[d]   = 1'b1;
    slv_sel[d]  = sel;
    slv_byte[d] = sb;
    slv_loop[d] = lp;
    slv_bit[d]  = (d == 1) ? 1'($urandom) : sb[7];
    @(posedge clk);
    #1;
    acc = cyc;
    erx = (int'(sel) < numm(d)) ? (lp ? tx : sb) : 8'h00;
    qpush(d, {16'(acc + 16 * hh(d) + 1), tx, erx});
    @(negedge clk);
    txdv_v[d] = 1'b0;
    sel_v[d]  = 3'($urandom);
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (qsize(d) != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("drain_d%0d", d), 32'(qsize(d)), 32'd0);
  endtask

  initial begin
    int acc, acc2;
    for (int d = 0; d < 3; d++) begin
      tx_v[d] = '0; txdv_v[d] = 1'b0; sel_v[d] = '0;
      slv_sel[d] = '0; slv_loop[d] = 1'b0; slv_bit[d] = 1'b0; slv_byte[d] = '0;
      noise[d] = '0; noise_rand[d] = 1'b1;
    end

    // reset values
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_sclk_d%0d", d), {31'd0, sclk_v[d]}, (d == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rst_mosi_d%0d", d), {31'd0, mosi_v[d]}, 32'd0);
      chk($sformatf("rst_ready_d%0d", d), {31'd0, rdy_v[d]}, 32'd0);
      chk($sformatf("rst_rxdv_d%0d", d), {31'd0, dv_v[d]}, 32'd0);
      chk($sformatf("rst_rx_d%0d", d), {24'd0, rx_v[d]}, 32'd0);
    end
    rst = 1'b0;
    #1 chk("ready_before_edge", {31'd0, rdy_v[0]}, 32'd0);
    @(posedge clk);
    #1 chk("ready_after_release", {31'd0, rdy_v[0]}, 32'd1);

    // mode 0 loopback of A5
    send(0, 8'hA5, 3'd0, 8'h00, 1'b1, acc);
    drain(0);

    // mode 3, slave returns 3C on line 5
    chk("mode3_idle_sclk", {31'd0, sclk_v[1]}, 32'd1);
    send(1, 8'hFF, 3'd5, 8'h3C, 1'b0, acc);
    drain(1);

    // back-to-back: second strobe lands in the DONE cycle
    send(0, 8'h01, 3'd0, 8'h00, 1'b1, acc);
    send(0, 8'h80, 3'd0, 8'h00, 1'b1, acc2);
    chk("b2b_accept_gap", 32'(acc2 - acc), 32'd34);
    drain(0);

    // strobe while busy is ignored
    send(0, 8'hC3, 3'd0, 8'h00, 1'b1, acc);
    while (cyc != acc + 10) begin
      @(posedge clk);
      #1;
    end
    tx_v[0]   = 8'h55;
    txdv_v[0] = 1'b1;
    @(posedge clk);
    #1 txdv_v[0] = 1'b0;
    drain(0);

    // mid-byte reset
    send(0, 8'hE7, 3'd0, 8'h00, 1'b1, acc);
    while (cyc != acc + 15) begin
      @(posedge clk);
      #1;
    end
    #1 chk("sclk_before_abort", {31'd0, sclk_v[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_sclk", {31'd0, sclk_v[0]}, 32'd0);
    chk("abort_mosi", {31'd0, mosi_v[0]}, 32'd0);
    chk("abort_ready", {31'd0, rdy_v[0]}, 32'd0);
    chk("abort_rxdv", {31'd0, dv_v[0]}, 32'd0);
    chk("abort_rx", {24'd0, rx_v[0]}, 32'd0);
    exp_q0.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_abort", {31'd0, rdy_v[0]}, 32'd1);
    send(0, 8'h5A, 3'd0, 8'h00, 1'b1, acc);
    drain(0);

    // out-of-range select with all lines high
    noise_rand[2] = 1'b0;
    noise[2]      = 8'hFF;
    send(2, 8'h96, 3'd6, 8'hFF, 1'b0, acc);
    drain(2);
    send(2, 8'h3B, 3'd4, 8'hFF, 1'b1, acc);
    drain(2);
    noise_rand[2] = 1'b1;

    // randomized traffic on all instances
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < 3; d++) begin
        send(d, 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)), acc);
      end
    end
    for (int d = 0; d < 3; d++) drain(d);

    repeat (40) @(negedge clk);
    chk("queues_empty", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
